tri_bus_arbiter: RTL and testbench
==================================

Name: tri_bus_arbiter

Overview:
Round-robin arbiter and sequencer for a shared tri-state bus whose drivers are bufif1-style buffers with one enable per requester.
- Grants bus ownership to one requester at a time.
- Drives that requester's buffer enable.
- Inserts mandatory all-released turnaround cycles between owners so two drivers never overlap.
- Sits between N bus clients and the per-client tri-state enable pins of the shared bidirectional net.

Parameters:
N, 4, number of requesters / tri-state drivers (2..8)
TA_CYCLES, 1, bus turnaround cycles with every enable low between owners (1..7)
MAX_HOLD, 16, max consecutive owned cycles before forced release when another request is pending (2..255)

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
req  input  N  per-requester bus request, level, held until served or abandoned
gnt  output  N  one-hot registered grant
oe  output  N  one-hot registered tri-state enable, to the buffer enable pins
owner  output  $clog2(N)  index of current owner; 0 when none
owner_valid  output  1  high while a requester owns the bus
turnaround  output  1  high during turnaround cycles

Behaviour:
- Reset (async assert, rst_n=0): gnt=0, oe=0, owner=0, owner_valid=0, turnaround=0, state=IDLE, rr pointer=0, hold counter=0. Every oe bit drops without waiting for clk. Deassertion is used synchronously; the first arbitration can occur on the first edge after release.
- States: IDLE, OWN, TA.
- IDLE:
  - If req!=0, select the first set bit at or after the rr pointer, wrapping.
  - On the next edge: gnt[k]=oe[k]=1, owner=k, owner_valid=1, state=OWN, hold=1.
  - Latency from req edge to gnt/oe is 1 cycle.
- OWN:
  - gnt and oe stay equal and one-hot.
  - Each cycle the hold counter increments, saturating at MAX_HOLD.
  - Release condition: req[owner]=0, or (hold==MAX_HOLD and any other req bit set).
  - If hold==MAX_HOLD and no other request is pending, ownership continues and hold reloads to 1.
  - On release, the next edge gives gnt=0, oe=0, owner_valid=0, rr pointer=(owner+1) mod N, state=TA, turnaround=1, TA counter=1.
- TA:
  - oe=0 for exactly TA_CYCLES cycles.
  - On the edge ending the last TA cycle, arbitrate as in IDLE. If req!=0, go directly to OWN with the new gnt/oe; otherwise go to IDLE.
  - turnaround=0 whenever the state is not TA.
  - A requester dropping or raising req during TA has no effect until that arbitration edge.
- Invariants:
  - oe is one-hot0 at all times.
  - Between any two different owners, at least TA_CYCLES cycles have oe==0.
  - Re-grant to the same requester also passes through TA, since it always releases first.
  - gnt==oe at all times.
- Boundary cases:
  - Pointer wraps from N-1 to 0.
  - If the owner drops req on the same cycle hold reaches MAX_HOLD, it takes the normal release path, counted once.
  - If all N request together after reset, order is 0,1,2,…,N-1.
  - Reset during OWN or TA aborts immediately to the reset values.

Decomposition:
- Shared package tri_bus_pkg: state enum (IDLE, OWN, TA), IDX_W/counter width constants, default parameter values.
- Sub-module rr_pick: purely combinational round-robin selector.
  - Inputs: req[N], ptr.
  - Outputs: any, idx, onehot.
  - Instantiated once in the arbiter.

Test Plan:
- Reset mid-own: N=4. req=0010; after 3 cycles in OWN, drop rst_n between edges. oe=0 immediately, owner_valid=0; after release, re-grant of requester 1 one cycle later.
- Single request: req=0100 from cycle 0, dropped at cycle 5. gnt=oe=0100 cycles 1–5, cycle 6 oe=0 turnaround=1, cycle 7 IDLE with all outputs 0.
- Full contention: req=1111 held, TA_CYCLES=1, MAX_HOLD=4. Owners 0,1,2,3,0 each for 4 cycles, one oe=0 gap between them, no cycle with two oe bits.
- Starvation bound: req[0] held continuously, req[2] raised at cycle 2. Requester 0 released after hold=MAX_HOLD (16 cycles), 1 TA cycle, then owner=2.
- Lone long owner: only req[3] held 40 cycles, MAX_HOLD=16. oe[3] stays high for all 40 cycles with no TA inserted; turnaround=0 throughout.
- TA_CYCLES=3 handover: owner 1 drops while req[2]=1. Exactly 3 cycles with oe=0 turnaround=1, then oe=0100; req[2] pulsed low during TA is ignored if high at the arbitration edge.

Source files
------------

// File: rtl/tri_bus_pkg.sv
// Shared types and constants for the tri-state bus arbiter and its round-robin selector.
package tri_bus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      OWN,
      TA
   } state_t;

   localparam int HOLD_W        = 8;
   localparam int TA_W          = 3;
   localparam int DEF_N         = 4;
   localparam int DEF_TA_CYCLES = 1;
   localparam int DEF_MAX_HOLD  = 16;

endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping at N-1.
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] idx,
   output logic [N-1:0]     onehot
);

   logic [IDX_W-1:0] cand;

   // Scan from the farthest offset back toward ptr so the nearest hit wins.
   always_comb begin
      any    = |req;
      idx    = '0;
      onehot = '0;
      cand   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         cand = IDX_W'((int'(ptr) + i) % N);
         if (req[cand]) begin
            idx = cand;
         end
      end
      if (any) begin
         onehot[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner sequencer for a shared tri-state bus, with forced all-off turnaround between owners.
module tri_bus_arbiter
   import tri_bus_pkg::*;
#(
   parameter int N         = DEF_N,
   parameter int TA_CYCLES = DEF_TA_CYCLES,
   parameter int MAX_HOLD  = DEF_MAX_HOLD
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         gnt,
   output logic [N-1:0]         oe,
   output logic [$clog2(N)-1:0] owner,
   output logic                 owner_valid,
   output logic                 turnaround
);

   localparam int IDX_W = $clog2(N);

   state_t            state_q, state_d;
   logic [N-1:0]      gnt_q, gnt_d;
   logic [IDX_W-1:0]  owner_q, owner_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic              valid_q, valid_d;
   logic              ta_flag_q, ta_flag_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [TA_W-1:0]   ta_q, ta_d;

   logic              pick_any;
   logic [IDX_W-1:0]  pick_idx;
   logic [N-1:0]      pick_onehot;
   logic              owner_req;
   logic              other_req;
   logic              hold_max;
   logic              release_now;

   rr_pick #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .any    (pick_any),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

   assign owner_req   = |(req & gnt_q);
   assign other_req   = |(req & ~gnt_q);
   assign hold_max    = (hold_q == HOLD_W'(MAX_HOLD));
   assign release_now = !owner_req || (hold_max && other_req);

   // One register drives both gnt and oe, so the two can never disagree.
   assign gnt         = gnt_q;
   assign oe          = gnt_q;
   assign owner       = owner_q;
   assign owner_valid = valid_q;
   assign turnaround  = ta_flag_q;

   // Next-state logic; arbitration happens from IDLE or at the end of the last turnaround cycle.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      valid_d   = valid_q;
      ta_flag_d = 1'b0;
      hold_d    = hold_q;
      ta_d      = ta_q;

      case (state_q)
         OWN: begin
            if (release_now) begin
               state_d   = TA;
               gnt_d     = '0;
               owner_d   = '0;
               valid_d   = 1'b0;
               ptr_d     = (owner_q == IDX_W'(N - 1)) ? '0 : owner_q + IDX_W'(1);
               ta_flag_d = 1'b1;
               ta_d      = TA_W'(1);
            end else if (hold_max) begin
               hold_d = HOLD_W'(1);
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         TA: begin
            if (ta_q != TA_W'(TA_CYCLES)) begin
               ta_d      = ta_q + TA_W'(1);
               ta_flag_d = 1'b1;
            end else if (pick_any) begin
               state_d = OWN;
               gnt_d   = pick_onehot;
               owner_d = pick_idx;
               valid_d = 1'b1;
               hold_d  = HOLD_W'(1);
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            if (pick_any) begin
               state_d = OWN;
               gnt_d   = pick_onehot;
               owner_d = pick_idx;
               valid_d = 1'b1;
               hold_d  = HOLD_W'(1);
            end
         end
      endcase
   end

   // Asynchronous reset clears every enable at once, without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         owner_q   <= '0;
         ptr_q     <= '0;
         valid_q   <= 1'b0;
         ta_flag_q <= 1'b0;
         hold_q    <= '0;
         ta_q      <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         valid_q   <= valid_d;
         ta_flag_q <= ta_flag_d;
         hold_q    <= hold_d;
         ta_q      <= ta_d;
      end
   end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Self-checking bench: three arbiter configurations share one request stream and are checked against a behavioural model.
module tb_tri_bus_arbiter;

   localparam int NI = 3;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;

   logic [3:0] gnt_w [NI];
   logic [3:0] oe_w  [NI];
   logic [1:0] own_w [NI];
   logic       ov_w  [NI];
   logic       ta_w  [NI];

   int checks;
   int errors;

   int ta_p [NI];
   int mh_p [NI];
   int m_owner [NI];
   int m_hold  [NI];
   int m_gap   [NI];
   int m_ptr   [NI];

   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] owner;
      logic       ov;
      logic       ta;
   } vec_t;

   vec_t tbl [17];

   // Instance 0: TA=1 MAX_HOLD=16, instance 1: TA=1 MAX_HOLD=4, instance 2: TA=3 MAX_HOLD=16.
   for (genvar g = 0; g < NI; g++) begin : g_dut
      tri_bus_arbiter #(
         .N         (4),
         .TA_CYCLES ((g == 2) ? 3 : 1),
         .MAX_HOLD  ((g == 1) ? 4 : 16)
      ) dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .req         (req),
         .gnt         (gnt_w[g]),
         .oe          (oe_w[g]),
         .owner       (own_w[g]),
         .owner_valid (ov_w[g]),
         .turnaround  (ta_w[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic modelReset();
      for (int i = 0; i < NI; i++) begin
         m_owner[i] = -1;
         m_hold[i]  = 0;
         m_gap[i]   = 0;
         m_ptr[i]   = 0;
      end
   endtask

   // Owner is -1 when the bus is free; m_gap counts turnaround cycles still to be spent, current one included.
   task automatic modelStep(input logic [3:0] r);
      for (int i = 0; i < NI; i++) begin
         bit arb;
         int o;
         int others;
         arb = 1'b0;
         if (m_owner[i] >= 0) begin
            o = m_owner[i];
            others = 0;
            for (int k = 0; k < 4; k++) if (k != o && r[k]) others++;
            if (!r[o] || (m_hold[i] == mh_p[i] && others > 0)) begin
               m_ptr[i]   = (o + 1) % 4;
               m_owner[i] = -1;
               m_gap[i]   = ta_p[i];
            end else begin
               m_hold[i] = (m_hold[i] == mh_p[i]) ? 1 : m_hold[i] + 1;
            end
         end else if (m_gap[i] > 1) begin
            m_gap[i]--;
         end else begin
            m_gap[i] = 0;
            arb = 1'b1;
         end
         if (arb) begin
            for (int k = 3; k >= 0; k--) begin
               if (r[(m_ptr[i] + k) % 4]) m_owner[i] = (m_ptr[i] + k) % 4;
            end
            if (m_owner[i] >= 0) m_hold[i] = 1;
         end
      end
   endtask

   function automatic logic [11:0] modelOut(input int i);
      logic [3:0] g;
      logic [1:0] o;
      g = (m_owner[i] >= 0) ? (4'b0001 << m_owner[i]) : 4'b0000;
      o = (m_owner[i] >= 0) ? 2'(m_owner[i]) : 2'd0;
      return {g, g, o, (m_owner[i] >= 0), (m_gap[i] > 0)};
   endfunction

   task automatic checkOutput(input string nm);
      logic [11:0] act;
      logic [11:0] exp;
      for (int i = 0; i < NI; i++) begin
         act = {gnt_w[i], oe_w[i], own_w[i], ov_w[i], ta_w[i]};
         exp = modelOut(i);
         checks++;
         if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d {gnt,oe,owner,valid,ta} got=%b want=%b at %0t", nm, i, act, exp, $time);
         end
      end
   endtask

   task automatic expectDut(input string nm, input int i, input logic [3:0] g,
                            input logic [1:0] o, input logic v, input logic t);
      logic [11:0] act;
      logic [11:0] exp;
      act = {gnt_w[i], oe_w[i], own_w[i], ov_w[i], ta_w[i]};
      exp = {g, g, o, v, t};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s dut%0d {gnt,oe,owner,valid,ta} got=%b want=%b at %0t", nm, i, act, exp, $time);
      end
   endtask

   // One clock: drive req, advance the model at the edge, sample 1 time unit later.
   task automatic applyStimulus(input logic [3:0] r, input string nm);
      req = r;
      @(posedge clk);
      if (rst_n) modelStep(r);
      #1;
      checkOutput(nm);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      req   = 4'b0000;
      modelReset();
      #1;
      checkOutput("reset");
      @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0] r;
      logic [3:0] g;
      int         o;

      checks = 0;
      errors = 0;
      ta_p[0] = 1; mh_p[0] = 16;
      ta_p[1] = 1; mh_p[1] = 4;
      ta_p[2] = 3; mh_p[2] = 16;
      rst_n = 1'b0;
      req   = 4'b0000;
      modelReset();

      tbl[0]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
      tbl[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
      tbl[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
      tbl[3]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
      tbl[4]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
      tbl[5]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1};
      tbl[6]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
      tbl[7]  = '{4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0};
      tbl[8]  = '{4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0};
      tbl[9]  = '{4'b0010, 4'b0000, 2'd0, 1'b0, 1'b1};
      tbl[10] = '{4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0};
      tbl[11] = '{4'b1000, 4'b0000, 2'd0, 1'b0, 1'b1};
      tbl[12] = '{4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0};
      tbl[13] = '{4'b0001, 4'b0000, 2'd0, 1'b0, 1'b1};
      tbl[14] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
      tbl[15] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1};
      tbl[16] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

      doReset();
      for (int v = 0; v < 17; v++) begin
         applyStimulus(tbl[v].req, "table");
         expectDut($sformatf("table[%0d]", v), 0, tbl[v].gnt, tbl[v].owner, tbl[v].ov, tbl[v].ta);
      end

      // Full contention on the MAX_HOLD=4 instance: 4 owned cycles then one gap, owners 0..3 then 0.
      doReset();
      for (int c = 1; c <= 24; c++) begin
         applyStimulus(4'b1111, "contention");
         if ((c - 1) % 5 == 4) begin
            expectDut("contention_gap", 1, 4'b0000, 2'd0, 1'b0, 1'b1);
         end else begin
            o = ((c - 1) / 5) % 4;
            g = 4'b0001 << o;
            expectDut("contention_own", 1, g, 2'(o), 1'b1, 1'b0);
         end
      end

      // Starvation bound: requester 0 is forced off after 16 cycles once requester 2 waits.
      doReset();
      for (int c = 1; c <= 18; c++) begin
         applyStimulus((c <= 2) ? 4'b0001 : 4'b0101, "starve");
         if (c <= 16)       expectDut("starve_own0", 0, 4'b0001, 2'd0, 1'b1, 1'b0);
         else if (c == 17)  expectDut("starve_ta",   0, 4'b0000, 2'd0, 1'b0, 1'b1);
         else               expectDut("starve_own2", 0, 4'b0100, 2'd2, 1'b1, 1'b0);
      end

      // Lone long owner: no turnaround when nobody else is waiting.
      doReset();
      for (int c = 1; c <= 40; c++) begin
         applyStimulus(4'b1000, "lone");
         expectDut("lone_mh16", 0, 4'b1000, 2'd3, 1'b1, 1'b0);
         expectDut("lone_mh4",  1, 4'b1000, 2'd3, 1'b1, 1'b0);
      end

      // Three-cycle turnaround with req[2] pulsed low mid-gap.
      doReset();
      applyStimulus(4'b0010, "ta3");
      expectDut("ta3_own1", 2, 4'b0010, 2'd1, 1'b1, 1'b0);
      applyStimulus(4'b0010, "ta3");
      applyStimulus(4'b0100, "ta3");
      expectDut("ta3_gap1", 2, 4'b0000, 2'd0, 1'b0, 1'b1);
      applyStimulus(4'b0000, "ta3");
      expectDut("ta3_gap2", 2, 4'b0000, 2'd0, 1'b0, 1'b1);
      applyStimulus(4'b0100, "ta3");
      expectDut("ta3_gap3", 2, 4'b0000, 2'd0, 1'b0, 1'b1);
      applyStimulus(4'b0100, "ta3");
      expectDut("ta3_own2", 2, 4'b0100, 2'd2, 1'b1, 1'b0);

      // Reset between edges while owning: enables drop at once, re-grant one edge after release.
      doReset();
      for (int c = 0; c < 3; c++) applyStimulus(4'b0010, "midrst_own");
      #2;
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("midrst_async");
      for (int i = 0; i < NI; i++) expectDut("midrst_off", i, 4'b0000, 2'd0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b1;
      applyStimulus(4'b0010, "midrst_regrant");
      for (int i = 0; i < NI; i++) expectDut("midrst_regrant", i, 4'b0010, 2'd1, 1'b1, 1'b0);

      // Randomised request traffic with sticky bits and occasional asynchronous resets.
      doReset();
      r = 4'b0000;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
         applyStimulus(r, "random");
         if ($urandom_range(0, 499) == 0) begin
            #2;
            rst_n = 1'b0;
            modelReset();
            #1;
            checkOutput("random_reset");
            #2;
            rst_n = 1'b1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
